// File: rtl/chip8_alu_sequencer_pkg.sv
// Shared definitions for the CHIP-8 8XYN ALU sequencer: ALU op codes,
// sequencer FSM states, the flag register index and the N-field decoder.
package chip8_alu_sequencer_pkg;

  localparam int         CHIP8_DATA_W     = 8;
  localparam int         CHIP8_REG_ADDR_W = 4;
  localparam logic [3:0] CHIP8_FLAG_REG   = 4'hF;

  typedef enum logic [2:0] {
    ALU_Y           = 3'd0,
    ALU_OR          = 3'd1,
    ALU_AND         = 3'd2,
    ALU_XOR         = 3'd3,
    ALU_PLUS        = 3'd4,
    ALU_MINUS       = 3'd5,
    ALU_SHIFT_RIGHT = 3'd6,
    ALU_SHIFT_LEFT  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_X = 3'd1,
    S_RD_Y = 3'd2,
    S_EXEC = 3'd3,
    S_WR_X = 3'd4,
    S_WR_F = 3'd5,
    S_DONE = 3'd6
  } seq_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    swap;   // feed VY as the left operand (SUBN)
    logic    flag;   // op produces a VF write
    logic    legal;
  } op_decode_t;

  // Map a full 8XYN instruction onto an ALU operation.
  function automatic op_decode_t decode_op(input logic [15:0] instr);
    op_decode_t d;
    d.op    = ALU_Y;
    d.swap  = 1'b0;
    d.flag  = 1'b0;
    d.legal = (instr[15:12] == 4'h8);
    case (instr[3:0])
      4'h0: d.op = ALU_Y;
      4'h1: d.op = ALU_OR;
      4'h2: d.op = ALU_AND;
      4'h3: d.op = ALU_XOR;
      4'h4: begin d.op = ALU_PLUS;        d.flag = 1'b1; end
      4'h5: begin d.op = ALU_MINUS;       d.flag = 1'b1; end
      4'h6: begin d.op = ALU_SHIFT_RIGHT; d.flag = 1'b1; end
      4'h7: begin d.op = ALU_MINUS;       d.flag = 1'b1; d.swap = 1'b1; end
      4'hE: begin d.op = ALU_SHIFT_LEFT;  d.flag = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/chip8_alu_sequencer_alu.sv
// Combinational CHIP-8 ALU: one result plus the carry/borrow/shift-out bit.
module chip8_alu_sequencer_alu
  import chip8_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = CHIP8_DATA_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [2:0]        operation,
  output logic [DATA_W-1:0] out,
  output logic              carry_out
);

  // Evaluate the selected operation; carry is 0 for the pure logic ops.
  always_comb begin
    out       = '0;
    carry_out = 1'b0;
    case (alu_op_e'(operation))
      ALU_Y:   out = y;
      ALU_OR:  out = x | y;
      ALU_AND: out = x & y;
      ALU_XOR: out = x ^ y;
      ALU_PLUS: {carry_out, out} = {1'b0, x} + {1'b0, y};
      ALU_MINUS: begin
        out       = x - y;
        carry_out = (x > y);
      end
      ALU_SHIFT_RIGHT: begin
        out       = x >> 1;
        carry_out = x[0];
      end
      ALU_SHIFT_LEFT: begin
        out       = x << 1;
        carry_out = x[DATA_W-1];
      end
      default: begin
        out       = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Sequences one 8XYN instruction over a single-port V-register file:
// read VX, read VY, execute, write VX, optionally write VF, pulse done.
module chip8_alu_sequencer
  import chip8_alu_sequencer_pkg::*;
#(
  parameter int                    DATA_W     = CHIP8_DATA_W,
  parameter int                    REG_ADDR_W = CHIP8_REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] FLAG_REG   = CHIP8_FLAG_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           opcode,
  output logic                  ready,
  output logic                  done,
  output logic                  illegal,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic                  rf_rd_en,
  input  logic [DATA_W-1:0]     rf_rd_data,
  output logic                  rf_wr_en,
  output logic [DATA_W-1:0]     rf_wr_data
);

  seq_state_e            state;
  op_decode_t            dec;
  logic [REG_ADDR_W-1:0] x_idx, y_idx;
  logic [2:0]            op_q;
  logic                  swap_q, flag_q;
  logic [DATA_W-1:0]     op_x;
  logic                  carry_q;
  logic [DATA_W-1:0]     alu_a, alu_b, alu_out;
  logic                  alu_carry;

  assign dec = decode_op(opcode);

  // VY is consumed straight off the read port in EXEC, so the ALU result is
  // ready to register at the end of that cycle. SUBN swaps the operands.
  assign alu_a = swap_q ? rf_rd_data : op_x;
  assign alu_b = swap_q ? op_x       : rf_rd_data;

  chip8_alu_sequencer_alu #(.DATA_W(DATA_W)) u_alu (
    .x         (alu_a),
    .y         (alu_b),
    .operation (op_q),
    .out       (alu_out),
    .carry_out (alu_carry)
  );

  // Sequencer FSM; all outputs registered. rf_wr_data doubles as the result
  // register so the VX write needs no extra staging flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      illegal    <= 1'b0;
      rf_addr    <= '0;
      rf_rd_en   <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_data <= '0;
      x_idx      <= '0;
      y_idx      <= '0;
      op_q       <= '0;
      swap_q     <= 1'b0;
      flag_q     <= 1'b0;
      op_x       <= '0;
      carry_q    <= 1'b0;
    end else begin
      done     <= 1'b0;
      illegal  <= 1'b0;
      rf_rd_en <= 1'b0;
      rf_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (dec.legal) begin
              state    <= S_RD_X;
              ready    <= 1'b0;
              x_idx    <= REG_ADDR_W'(opcode[11:8]);
              y_idx    <= REG_ADDR_W'(opcode[7:4]);
              op_q     <= dec.op;
              swap_q   <= dec.swap;
              flag_q   <= dec.flag;
              rf_addr  <= REG_ADDR_W'(opcode[11:8]);
              rf_rd_en <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_RD_X: begin
          state    <= S_RD_Y;
          rf_addr  <= y_idx;
          rf_rd_en <= 1'b1;
        end
        S_RD_Y: begin
          op_x  <= rf_rd_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          rf_wr_data <= alu_out;
          carry_q    <= alu_carry;
          rf_addr    <= x_idx;
          rf_wr_en   <= 1'b1;
          state      <= S_WR_X;
        end
        S_WR_X: begin
          if (flag_q) begin
            state      <= S_WR_F;
            rf_addr    <= FLAG_REG;
            rf_wr_en   <= 1'b1;
            rf_wr_data <= DATA_W'(carry_q);
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_WR_F: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer with a behavioural register file.
module tb_chip8_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] opcode;
  logic        ready, done, illegal;
  logic [3:0]  rf_addr;
  logic        rf_rd_en, rf_wr_en;
  logic [7:0]  rf_rd_data, rf_wr_data;

  logic [7:0]  rf [16];
  logic        tb_wr;
  logic [3:0]  tb_addr;
  logic [7:0]  tb_data;

  int checks   = 0;
  int failures = 0;

  chip8_alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .ready      (ready),
    .done       (done),
    .illegal    (illegal),
    .rf_addr    (rf_addr),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_data (rf_wr_data)
  );

  always #5 clk = ~clk;

  // Register file: 1-cycle registered read, write at the edge. The bench
  // preloads through its own port while the DUT is idle.
  always @(posedge clk) begin
    if (tb_wr) rf[tb_addr] <= tb_data;
    else if (rf_wr_en) rf[rf_addr] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= rf[rf_addr];
  end

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  // Issue op at edge 0, optionally pulse start again in cycle 'poke' with
  // poke_op, and record per-cycle observations for ncyc cycles.
  task automatic run_op(input logic [15:0] op, input int poke, input logic [15:0] poke_op,
                        input int ncyc, output int first_done, output int n_done,
                        output int first_ill, output logic [31:0] rdy_bits,
                        output logic [31:0] acc_bits, output int conflicts);
    first_done = 0; n_done = 0; first_ill = 0; rdy_bits = '0; acc_bits = '0; conflicts = 0;
    opcode = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == poke) begin start = 1'b1; opcode = poke_op; end
      @(negedge clk);
      if (done) begin n_done++; if (first_done == 0) first_done = c; end
      if (illegal && first_ill == 0) first_ill = c;
      rdy_bits[c] = ready;
      acc_bits[c] = rf_rd_en | rf_wr_en;
      if (rf_rd_en && rf_wr_en) conflicts++;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = 16'h0; tb_wr = 1'b0; tb_addr = 4'h0; tb_data = 8'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if ({done, illegal, rf_rd_en, rf_wr_en} !== 4'b0000) begin failures++;
      $display("FAIL reset_strobes got=%b exp=0000", {done, illegal, rf_rd_en, rf_wr_en}); end
    checks++; if ({rf_addr, rf_wr_data} !== 12'h000) begin failures++;
      $display("FAIL reset_addr_data got=%h exp=000", {rf_addr, rf_wr_data}); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h20);
    run_op(16'h8124, 0, 16'h0, 9, fd, nd, fi, rb, ab, cf);
    checks++; if (rf[1] !== 8'h10) begin failures++; $display("FAIL add_v1 got=%h exp=10", rf[1]); end
    checks++; if (rf[15] !== 8'h01) begin failures++; $display("FAIL add_vf got=%h exp=01", rf[15]); end
    checks++; if (fd != 6 || nd != 1) begin failures++; $display("FAIL add_done got=cyc%0d n%0d exp=cyc6 n1", fd, nd); end
    checks++; if (rb[7:1] !== 7'b1000000) begin failures++; $display("FAIL add_ready got=%b exp=1000000", rb[7:1]); end
    checks++; if (cf != 0) begin failures++; $display("FAIL add_rdwr_overlap got=%0d exp=0", cf); end
  endtask

  task automatic test_subn();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'h05); set_reg(4'h2, 8'h03);
    run_op(16'h8127, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[1], rf[15]} !== 16'hFE00) begin failures++;
      $display("FAIL subn_borrow got=%h exp=FE00", {rf[1], rf[15]}); end
    set_reg(4'h1, 8'h03); set_reg(4'h2, 8'h05);
    run_op(16'h8127, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[1], rf[15]} !== 16'h0201) begin failures++;
      $display("FAIL subn_noborrow got=%h exp=0201", {rf[1], rf[15]}); end
    set_reg(4'h3, 8'h09); set_reg(4'h4, 8'h09);
    run_op(16'h8345, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[3], rf[15]} !== 16'h0000) begin failures++;
      $display("FAIL sub_equal got=%h exp=0000", {rf[3], rf[15]}); end
  endtask

  task automatic test_shift();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'h81);
    run_op(16'h812E, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[1], rf[15]} !== 16'h0201) begin failures++;
      $display("FAIL shl got=%h exp=0201", {rf[1], rf[15]}); end
    set_reg(4'h1, 8'h81);
    run_op(16'h8126, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[1], rf[15]} !== 16'h4001) begin failures++;
      $display("FAIL shr got=%h exp=4001", {rf[1], rf[15]}); end
  endtask

  task automatic test_logic_ops();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'h0F); set_reg(4'h2, 8'hF0); set_reg(4'hF, 8'h55);
    run_op(16'h8121, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if ({rf[1], rf[15]} !== 16'hFF55) begin failures++;
      $display("FAIL or_result got=%h exp=FF55", {rf[1], rf[15]}); end
    checks++; if (fd != 5 || nd != 1) begin failures++; $display("FAIL or_done got=cyc%0d n%0d exp=cyc5 n1", fd, nd); end
    checks++; if (rb[6:1] !== 6'b100000) begin failures++; $display("FAIL or_ready got=%b exp=100000", rb[6:1]); end
    set_reg(4'h5, 8'h3C); set_reg(4'h6, 8'hA5);
    run_op(16'h8563, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if (rf[5] !== 8'h99) begin failures++; $display("FAIL xor got=%h exp=99", rf[5]); end
    run_op(16'h8560, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if (rf[5] !== 8'hA5) begin failures++; $display("FAIL mov got=%h exp=A5", rf[5]); end
  endtask

  task automatic test_flag_override();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'hF, 8'hFF); set_reg(4'h1, 8'h01);
    run_op(16'h8F14, 0, 16'h0, 8, fd, nd, fi, rb, ab, cf);
    checks++; if (rf[15] !== 8'h01) begin failures++; $display("FAIL flag_wins got=%h exp=01", rf[15]); end
  endtask

  task automatic test_illegal();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    run_op(16'h8128, 0, 16'h0, 4, fd, nd, fi, rb, ab, cf);
    checks++; if (fi != 1) begin failures++; $display("FAIL illegal_pulse got=cyc%0d exp=cyc1", fi); end
    checks++; if (ab[4:1] !== 4'h0 || nd != 0) begin failures++;
      $display("FAIL illegal_quiet got=acc%b n%0d exp=acc0000 n0", ab[4:1], nd); end
    checks++; if (rb[4:1] !== 4'hF) begin failures++; $display("FAIL illegal_ready got=%b exp=1111", rb[4:1]); end
    run_op(16'h9120, 0, 16'h0, 3, fd, nd, fi, rb, ab, cf);
    checks++; if (fi != 1 || ab[3:1] !== 3'b000) begin failures++;
      $display("FAIL illegal_major got=cyc%0d acc%b exp=cyc1 acc000", fi, ab[3:1]); end
  endtask

  task automatic test_reset_mid_op();
    int wr_seen = 0;
    logic rdy4;
    set_reg(4'h1, 8'h11); set_reg(4'h2, 8'h22); set_reg(4'hF, 8'h77);
    opcode = 16'h8124; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;       // edge 0
    @(posedge clk); @(posedge clk); #1;     // edges 1,2 -> now in EXEC
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;       // edge 3 samples reset
    @(negedge clk); rdy4 = ready;
    for (int c = 0; c < 5; c++) begin
      if (rf_wr_en) wr_seen++;
      @(negedge clk);
    end
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", rdy4); end
    checks++; if (wr_seen != 0) begin failures++; $display("FAIL rst_mid_write got=%0d exp=0", wr_seen); end
    checks++; if ({rf[1], rf[15]} !== 16'h1177) begin failures++;
      $display("FAIL rst_mid_regs got=%h exp=1177", {rf[1], rf[15]}); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'h0F); set_reg(4'h2, 8'hF0);
    run_op(16'h8121, 2, 16'h8122, 10, fd, nd, fi, rb, ab, cf);
    checks++; if (nd != 1 || fd != 5) begin failures++;
      $display("FAIL busy_start got=cyc%0d n%0d exp=cyc5 n1", fd, nd); end
    checks++; if (rf[1] !== 8'hFF) begin failures++; $display("FAIL busy_opcode got=%h exp=FF", rf[1]); end
  endtask

  task automatic test_back_to_back();
    int fd, nd, fi, cf; logic [31:0] rb, ab;
    set_reg(4'h1, 8'h01); set_reg(4'h2, 8'h02);
    run_op(16'h8124, 7, 16'h8122, 14, fd, nd, fi, rb, ab, cf);
    checks++; if (fd != 6 || nd != 2) begin failures++;
      $display("FAIL b2b_done got=cyc%0d n%0d exp=cyc6 n2", fd, nd); end
    checks++; if (rb[8:7] !== 2'b01) begin failures++; $display("FAIL b2b_accept got=%b exp=01", rb[8:7]); end
    checks++; if ({rf[1], rf[15]} !== 16'h0200) begin failures++;
      $display("FAIL b2b_regs got=%h exp=0200", {rf[1], rf[15]}); end
    checks++; if (cf != 0) begin failures++; $display("FAIL b2b_rdwr_overlap got=%0d exp=0", cf); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subn();
    test_shift();
    test_logic_ops();
    test_flag_override();
    test_illegal();
    test_reset_mid_op();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
